// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/consumer and the pwm_capture block.
// The master side drives the PWM and enable and reads back the measurements.
interface pwm_capture_if #(
    parameter int CNT_BITS = 16
);
    logic                enable;
    logic                pwm_in;
    logic [CNT_BITS-1:0] high_time;
    logic [CNT_BITS-1:0] period;
    logic                valid;
    logic                stalled;
    logic                stall_level;

    modport master (
        output enable,
        output pwm_in,
        input  high_time,
        input  period,
        input  valid,
        input  stalled,
        input  stall_level
    );

    modport slave (
        input  enable,
        input  pwm_in,
        output high_time,
        output period,
        output valid,
        output stalled,
        output stall_level
    );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous
// PWM input in clk cycles, posting one strobed result per period plus stall detection.
module pwm_capture #(
    parameter int CNT_BITS = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic         clk,
    input  logic         reset,
    pwm_capture_if.slave cap_io
);

    if (TIMEOUT < 2 || TIMEOUT > (2 ** CNT_BITS) - 1) begin : g_bad_timeout
        $error("pwm_capture: TIMEOUT must lie in [2, 2**CNT_BITS-1]");
    end

    localparam logic [CNT_BITS-1:0] TIMEOUT_C = CNT_BITS'(TIMEOUT);
    localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_e;

    state_e              state_q, state_d;
    logic                s1_q, s2_q, s3_q;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_BITS-1:0] hi_lat_q, hi_lat_d;
    logic [CNT_BITS-1:0] high_time_q, high_time_d;
    logic [CNT_BITS-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                stalled_q, stalled_d;
    logic                stall_level_q, stall_level_d;

    logic rise;
    logic fall;
    logic timeout;

    // s1/s2 form the metastability guard; s3 only serves edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= cap_io.pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign timeout = (cnt_q == TIMEOUT_C) && !rise && !fall;

    // Cycle counter restarts at 1 on each rise so that its value at the next rise equals the period.
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        hi_lat_d      = hi_lat_q;
        high_time_d   = high_time_q;
        period_d      = period_q;
        valid_d       = 1'b0;
        stalled_d     = stalled_q;
        stall_level_d = stall_level_q;

        if (!cap_io.enable) begin
            state_d   = ST_IDLE;
            stalled_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d   = ST_HIGH;
                        stalled_d = 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_d  = ST_LOW;
                        hi_lat_d = cnt_q;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_d     = ST_HIGH;
                        period_d    = cnt_q;
                        high_time_d = hi_lat_q;
                        valid_d     = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A stuck input posts a zero measurement once, then waits in IDLE for a rise.
            if (state_q != ST_IDLE && timeout) begin
                state_d       = ST_IDLE;
                stalled_d     = 1'b1;
                stall_level_d = s2_q;
                period_d      = '0;
                high_time_d   = '0;
                valid_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            hi_lat_q      <= '0;
            high_time_q   <= '0;
            period_q      <= '0;
            valid_q       <= 1'b0;
            stalled_q     <= 1'b0;
            stall_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_lat_q      <= hi_lat_d;
            high_time_q   <= high_time_d;
            period_q      <= period_d;
            valid_q       <= valid_d;
            stalled_q     <= stalled_d;
            stall_level_q <= stall_level_d;
        end
    end

    assign cap_io.high_time   = high_time_q;
    assign cap_io.period      = period_q;
    assign cap_io.valid       = valid_q;
    assign cap_io.stalled     = stalled_q;
    assign cap_io.stall_level = stall_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus random PWM segments, checked every
// cycle against a timestamp-based reference model of edges seen through the synchroniser.
module tb_pwm_capture;

    localparam int CNT_BITS = 16;
    localparam int TIMEOUT  = 100;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_BITS(CNT_BITS)) cap_if ();

    pwm_capture #(
        .CNT_BITS(CNT_BITS),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cap_io(cap_if)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: input levels sampled per edge, timestamps of the last rise and fall
    int k;
    bit p1, p2, p3;
    bit tracking, seen_fall;
    int t_rise, t_fall;
    bit e_valid, e_stalled, e_stall_level;
    int e_period, e_high;

    bit en;
    int n_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        p1 = 1'b0; p2 = 1'b0; p3 = 1'b0;
        tracking = 1'b0; seen_fall = 1'b0;
        e_valid = 1'b0; e_stalled = 1'b0; e_stall_level = 1'b0;
        e_period = 0; e_high = 0;
    endtask

    // The synchroniser lets an edge at the input be seen two edges after it is first sampled.
    task automatic model_edge(input bit lvl, input bit enb);
        bit r, f;
        r = p2 & ~p3;
        f = ~p2 & p3;
        e_valid = 1'b0;
        if (!enb) begin
            tracking  = 1'b0;
            e_stalled = 1'b0;
        end else if (r) begin
            if (tracking && seen_fall) begin
                e_valid  = 1'b1;
                e_period = k - t_rise;
                e_high   = t_fall - t_rise;
            end
            tracking  = 1'b1;
            seen_fall = 1'b0;
            t_rise    = k;
            e_stalled = 1'b0;
        end else if (tracking) begin
            if (f) begin
                if (!seen_fall) begin
                    seen_fall = 1'b1;
                    t_fall    = k;
                end
            end else if (k - t_rise == TIMEOUT) begin
                tracking      = 1'b0;
                e_valid       = 1'b1;
                e_period      = 0;
                e_high        = 0;
                e_stalled     = 1'b1;
                e_stall_level = p2;
            end
        end
        p3 = p2;
        p2 = p1;
        p1 = lvl;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"},       32'(cap_if.valid),       32'(e_valid));
        chk({tag, ".period"},      32'(cap_if.period),      32'(e_period));
        chk({tag, ".high_time"},   32'(cap_if.high_time),   32'(e_high));
        chk({tag, ".stalled"},     32'(cap_if.stalled),     32'(e_stalled));
        chk({tag, ".stall_level"}, 32'(cap_if.stall_level), 32'(e_stall_level));
    endtask

    task automatic tick(input bit lvl);
        cap_if.pwm_in = lvl;
        cap_if.enable = en;
        @(posedge clk);
        k++;
        if (reset) model_reset();
        else       model_edge(lvl, en);
        #1;
        compare_all("cycle");
        if (cap_if.valid === 1'b1) n_valid++;
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            repeat (h) tick(1'b1);
            repeat (l) tick(1'b0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        en            = 1'b0;
        cap_if.enable = 1'b0;
        cap_if.pwm_in = 1'b0;
        k             = 0;
        n_valid       = 0;
        model_reset();
        #1;
        compare_all("reset");

        tick(1'b0);
        tick(1'b0);
        reset = 1'b0;
        en    = 1'b1;
        repeat (4) tick(1'b0);

        // 3/5 waveform: first rise arms, every later rise posts 3/8
        n_valid = 0;
        wave(3, 5, 6);
        chk("p35.count",     32'(n_valid),          32'd5);
        chk("p35.period",    32'(cap_if.period),    32'd8);
        chk("p35.high_time", 32'(cap_if.high_time), 32'd3);
        chk("p35.stalled",   32'(cap_if.stalled),   32'd0);

        // Minimum 1/1 waveform
        wave(1, 1, 10);
        chk("p11.period",    32'(cap_if.period),    32'd2);
        chk("p11.high_time", 32'(cap_if.high_time), 32'd1);

        // Input stuck low: one zero-measurement strobe, then silence
        repeat (5) tick(1'b0);
        n_valid = 0;
        repeat (105) tick(1'b0);
        chk("stall0.count",       32'(n_valid),            32'd1);
        chk("stall0.stalled",     32'(cap_if.stalled),     32'd1);
        chk("stall0.stall_level", 32'(cap_if.stall_level), 32'd0);
        chk("stall0.period",      32'(cap_if.period),      32'd0);
        chk("stall0.high_time",   32'(cap_if.high_time),   32'd0);

        // Rise clears the stall; holding high then stalls with level 1
        repeat (3) tick(1'b1);
        chk("stall_clear", 32'(cap_if.stalled), 32'd0);
        repeat (110) tick(1'b1);
        chk("stall1.stalled",     32'(cap_if.stalled),     32'd1);
        chk("stall1.stall_level", 32'(cap_if.stall_level), 32'd1);

        // Asynchronous reset during the high phase of a 4/4 waveform
        repeat (4) tick(1'b0);
        wave(4, 4, 3);
        tick(1'b1);
        tick(1'b1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        tick(1'b1);
        tick(1'b1);
        #2;
        reset = 1'b0;
        n_valid = 0;
        repeat (4) tick(1'b0);
        wave(4, 4, 4);
        chk("post_rst.count",     32'(n_valid),          32'd3);
        chk("post_rst.period",    32'(cap_if.period),    32'd8);
        chk("post_rst.high_time", 32'(cap_if.high_time), 32'd4);

        // Enable dropped for 10 cycles mid-stream
        wave(4, 4, 2);
        en = 1'b0;
        n_valid = 0;
        repeat (4) tick(1'b0);
        repeat (4) tick(1'b1);
        repeat (2) tick(1'b0);
        chk("en_low.count",   32'(n_valid),        32'd0);
        chk("en_low.stalled", 32'(cap_if.stalled), 32'd0);
        en = 1'b1;
        n_valid = 0;
        repeat (2) tick(1'b0);
        wave(4, 4, 3);
        chk("en_back.count",     32'(n_valid),          32'd2);
        chk("en_back.period",    32'(cap_if.period),    32'd8);
        chk("en_back.high_time", 32'(cap_if.high_time), 32'd4);

        // Random segments, occasional long phases and enable drops
        for (int s = 0; s < 150; s++) begin
            int h, l;
            h  = (($urandom % 20) == 0) ? int'($urandom_range(95, 130)) : int'($urandom_range(1, 12));
            l  = (($urandom % 20) == 0) ? int'($urandom_range(95, 130)) : int'($urandom_range(1, 12));
            en = (($urandom % 10) != 0);
            wave(h, l, 1);
        end
        en = 1'b1;
        wave(5, 7, 4);
        chk("rand_tail.period",    32'(cap_if.period),    32'd12);
        chk("rand_tail.high_time", 32'(cap_if.high_time), 32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
